// File: rtl/cv32e40p_obi_arbiter.sv
// N-to-1 OBI data-port arbiter: round-robin with request locking,
// in-order ID FIFO routes each response to the master that issued it.
module cv32e40p_obi_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_PORTS-1:0]          req_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  input  logic [NUM_PORTS-1:0]          we_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0] be_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]          rvalid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [DATA_W/8-1:0]           mem_be_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt_o,
  output logic                          err_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  logic [IDX_W-1:0] rr_ptr_q;
  logic             lock_vld_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] id_mem [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic [IDX_W-1:0] winner;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             pop;
  logic [IDX_W-1:0] head;

  // a + b modulo NUM_PORTS; both operands are already below NUM_PORTS
  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] a,
    input int unsigned      b
  );
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return s[IDX_W-1:0];
  endfunction

  // Round-robin scan; descending so the lowest offset from rr_ptr wins
  always_comb begin
    rr_idx  = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      cand = wrap_add(rr_ptr_q, i);
      if (req_i[cand]) begin
        rr_idx  = cand;
        any_req = 1'b1;
      end
    end
  end

  assign winner     = lock_vld_q ? lock_idx_q : rr_idx;
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
  assign fifo_empty = (cnt_q == '0);
  assign head       = id_mem[rd_ptr_q];

  assign mem_req_o   = (any_req | lock_vld_q) & ~fifo_full;
  assign mem_we_o    = we_i[winner];
  assign mem_be_o    = be_i[winner*BE_W +: BE_W];
  assign mem_addr_o  = addr_i[winner*ADDR_W +: ADDR_W];
  assign mem_wdata_o = wdata_i[winner*DATA_W +: DATA_W];

  assign accept = mem_req_o & mem_gnt_i;
  assign pop    = mem_rvalid_i & ~fifo_empty;

  assign rdata_o     = mem_rdata_i;
  assign outst_cnt_o = cnt_q;
  assign err_o       = err_q;

  // One-hot grant and response routing
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      gnt_o[k]    = accept & (winner == IDX_W'(k));
      rvalid_o[k] = pop & (head == IDX_W'(k));
    end
  end

  // Arbitration state: priority pointer and pending-request lock
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q   <= wrap_add(winner, 1);
        lock_vld_q <= 1'b0;
      end else if (mem_req_o) begin
        lock_vld_q <= 1'b1;
        lock_idx_q <= winner;
      end
    end
  end

  // ID FIFO pointers, occupancy and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(accept) - CNT_W'(pop);
      if (mem_rvalid_i & fifo_empty) err_q <= 1'b1;
    end
  end

  // ID FIFO storage; contents are only read behind the valid pointers
  always_ff @(posedge clk_i) begin
    if (accept) id_mem[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_cv32e40p_obi_arbiter.sv
// Directed vector bench for cv32e40p_obi_arbiter (4 ports, depth 4).
// Port k: addr fixed (port 2 from vector), wdata 0x5A00000k, be k+1.
module tb_cv32e40p_obi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [3:0]  we;
  logic [15:0] be;
  logic [127:0] addr;
  logic [127:0] wdata;
  logic [3:0]  rvalid;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [2:0]  cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_obi_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .gnt_o        (gnt),
    .we_i         (we),
    .be_i         (be),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .outst_cnt_o  (cnt),
    .err_o        (err)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic        gnt;
    logic        rv;
    logic [31:0] a2;
    logic [3:0]  e_gnt;
    logic [3:0]  e_rv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(
    logic [3:0] r, logic [3:0] w, logic g, logic v,
    logic [31:0] a2, logic [3:0] eg, logic [3:0] erv,
    logic ereq, logic [31:0] ea, logic ewe,
    logic [2:0] ec, logic ee
  );
    vec_t t;
    t = '{r, w, g, v, a2, eg, erv, ereq, ea, ewe, ec, ee};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_addr2(input logic [31:0] a2);
    addr = {32'h0000_00D0, a2, 32'h0000_00B0, 32'h0000_00A0};
  endtask

  task automatic idle();
    req = '0;
    we = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    set_addr2(32'h0000_00C0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".gnt"}, 32'(gnt), 32'd0);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, ".cnt"}, 32'(cnt), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    be = {4'd4, 4'd3, 4'd2, 4'd1};
    wdata = {32'h5A00_0003, 32'h5A00_0002, 32'h5A00_0001, 32'h5A00_0000};
    mem_rdata = 32'h0;
    idle();

    // single master, port 2
    vecs.push_back(mk(4'b0100,0,1,0,32'h100, 4'b0100,4'b0000,1,32'h100,0,0,0));
    vecs.push_back(mk(4'b0100,0,1,1,32'h104, 4'b0100,4'b0100,1,32'h104,0,1,0));
    vecs.push_back(mk(4'b0100,0,1,1,32'h108, 4'b0100,4'b0100,1,32'h108,0,1,0));
    vecs.push_back(mk(4'b0000,0,1,1,32'hC0,  4'b0000,4'b0100,0,32'h0,0,1,0));
    // round robin from rr_ptr=3
    vecs.push_back(mk(4'b1111,0,1,0,32'hC0,  4'b1000,4'b0000,1,32'hD0,0,0,0));
    vecs.push_back(mk(4'b1111,0,1,1,32'hC0,  4'b0001,4'b1000,1,32'hA0,0,1,0));
    vecs.push_back(mk(4'b1111,0,1,1,32'hC0,  4'b0010,4'b0001,1,32'hB0,0,1,0));
    vecs.push_back(mk(4'b1111,0,1,1,32'hC0,  4'b0100,4'b0010,1,32'hC0,0,1,0));
    vecs.push_back(mk(4'b1111,0,1,1,32'hC0,  4'b1000,4'b0100,1,32'hD0,0,1,0));
    vecs.push_back(mk(4'b1111,0,1,1,32'hC0,  4'b0001,4'b1000,1,32'hA0,0,1,0));
    vecs.push_back(mk(4'b1111,0,1,1,32'hC0,  4'b0010,4'b0001,1,32'hB0,0,1,0));
    vecs.push_back(mk(4'b1111,0,1,1,32'hC0,  4'b0100,4'b0010,1,32'hC0,0,1,0));
    vecs.push_back(mk(4'b0000,0,0,1,32'hC0,  4'b0000,4'b0100,0,32'h0,0,1,0));
    // lock on port 1 while port 0 joins
    vecs.push_back(mk(4'b0010,0,0,0,32'hC0,  4'b0000,4'b0000,1,32'hB0,0,0,0));
    vecs.push_back(mk(4'b0011,0,0,0,32'hC0,  4'b0000,4'b0000,1,32'hB0,0,0,0));
    vecs.push_back(mk(4'b0011,0,0,0,32'hC0,  4'b0000,4'b0000,1,32'hB0,0,0,0));
    vecs.push_back(mk(4'b0011,0,1,0,32'hC0,  4'b0010,4'b0000,1,32'hB0,0,0,0));
    vecs.push_back(mk(4'b0001,0,1,1,32'hC0,  4'b0001,4'b0010,1,32'hA0,0,1,0));
    vecs.push_back(mk(4'b0000,0,0,1,32'hC0,  4'b0000,4'b0001,0,32'h0,0,1,0));
    // fill FIFO from port 3
    vecs.push_back(mk(4'b1000,0,1,0,32'hC0,  4'b1000,4'b0000,1,32'hD0,0,0,0));
    vecs.push_back(mk(4'b1000,0,1,0,32'hC0,  4'b1000,4'b0000,1,32'hD0,0,1,0));
    vecs.push_back(mk(4'b1000,0,1,0,32'hC0,  4'b1000,4'b0000,1,32'hD0,0,2,0));
    vecs.push_back(mk(4'b1000,0,1,0,32'hC0,  4'b1000,4'b0000,1,32'hD0,0,3,0));
    vecs.push_back(mk(4'b1000,0,1,0,32'hC0,  4'b0000,4'b0000,0,32'h0,0,4,0));
    vecs.push_back(mk(4'b1000,0,1,1,32'hC0,  4'b0000,4'b1000,0,32'h0,0,4,0));
    vecs.push_back(mk(4'b1000,0,1,0,32'hC0,  4'b1000,4'b0000,1,32'hD0,0,3,0));
    vecs.push_back(mk(4'b0000,0,0,1,32'hC0,  4'b0000,4'b1000,0,32'h0,0,4,0));
    vecs.push_back(mk(4'b0000,0,0,1,32'hC0,  4'b0000,4'b1000,0,32'h0,0,3,0));
    vecs.push_back(mk(4'b0000,0,0,1,32'hC0,  4'b0000,4'b1000,0,32'h0,0,2,0));
    vecs.push_back(mk(4'b0000,0,0,1,32'hC0,  4'b0000,4'b1000,0,32'h0,0,1,0));
    // response for port 0 in port 2's grant cycle
    vecs.push_back(mk(4'b0001,4'b0001,1,0,32'hC0, 4'b0001,4'b0000,1,32'hA0,1,0,0));
    vecs.push_back(mk(4'b0100,4'b0100,1,1,32'hC0, 4'b0100,4'b0001,1,32'hC0,1,1,0));
    vecs.push_back(mk(4'b0000,0,0,1,32'hC0,  4'b0000,4'b0100,0,32'h0,0,1,0));
    // spurious response
    vecs.push_back(mk(4'b0000,0,0,1,32'hC0,  4'b0000,4'b0000,0,32'h0,0,0,0));
    vecs.push_back(mk(4'b0000,0,0,0,32'hC0,  4'b0000,4'b0000,0,32'h0,0,0,1));

    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      req = vecs[i].req;
      we = vecs[i].we;
      mem_gnt = vecs[i].gnt;
      mem_rvalid = vecs[i].rv;
      set_addr2(vecs[i].a2);
      @(negedge clk);
      chk({t, ".gnt"}, 32'(gnt), 32'(vecs[i].e_gnt));
      chk({t, ".rvalid"}, 32'(rvalid), 32'(vecs[i].e_rv));
      chk({t, ".mem_req"}, 32'(mem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) begin
        chk({t, ".mem_addr"}, mem_addr, vecs[i].e_addr);
        chk({t, ".mem_we"}, 32'(mem_we), 32'(vecs[i].e_we));
      end
      chk({t, ".cnt"}, 32'(cnt), 32'(vecs[i].e_cnt));
      chk({t, ".err"}, 32'(err), 32'(vecs[i].e_err));
      step();
    end

    // err holds, then one reset cycle clears everything
    idle();
    @(negedge clk);
    chk("err_hold", 32'(err), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst2");
    step();

    // attribute mux and rdata pass-through for port 2
    req = 4'b0100;
    we = 4'b0100;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mux.addr", mem_addr, 32'hC0);
    chk("mux.we", 32'(mem_we), 32'd1);
    chk("mux.wdata", mem_wdata, 32'h5A00_0002);
    chk("mux.be", 32'(mem_be), 32'h3);
    chk("rdata", rdata, 32'hDEAD_BEEF);
    step();
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("mid.gnt", 32'(gnt), 32'b0100);
    step();

    // reset with one transfer outstanding
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    chk("mid.cnt", 32'(cnt), 32'd0);
    chk("mid.rr_addr", mem_addr, 32'hA0);
    step();
    req = '0;
    mem_rvalid = 1'b1;
    @(negedge clk);
    chk("late.rvalid", 32'(rvalid), 32'd0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late.err", 32'(err), 32'd1);
    chk("late.cnt", 32'(cnt), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
